// File: rtl/systolic_feeder_2x2_pkg.sv
// Shared encodings for the 2x2 systolic array operand feeder.
package systolic_feeder_2x2_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned ARR_W  = 8;
    localparam int unsigned STEP_W = 2;
    localparam int unsigned TMO_W  = 4;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Element write addresses
    localparam logic [ADDR_W-1:0] ADDR_A00 = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_A01 = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_A10 = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_A11 = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_B00 = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_B01 = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_B10 = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_B11 = 3'd7;

    // Array control vectors
    localparam logic [ARR_W-1:0] ARR_NONE      = 8'h00;
    localparam logic [ARR_W-1:0] ARR_RESET_ALL = 8'hFF;
    localparam logic [ARR_W-1:0] ARR_START_PE  = 8'h0F;

    // Final skew step of the STREAM phase
    localparam logic [STEP_W-1:0] STEP_LAST = 2'd2;

endpackage

// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer and diagonal skew generator for the 2x2 systolic array.
module systolic_feeder_2x2
    import systolic_feeder_2x2_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [2:0]       load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             go,
    input  logic             arr_done,
    output logic [7:0]       arr_reset,
    output logic [7:0]       arr_start,
    output logic [WIDTH-1:0] west0,
    output logic [WIDTH-1:0] west1,
    output logic [WIDTH-1:0] north0,
    output logic [WIDTH-1:0] north1,
    output logic             busy,
    output logic             feed_done,
    output logic             timeout_err
);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                tmo_hit_c;
    logic                go_acc_c;

    logic [WIDTH-1:0]    a00, a01, a10, a11;
    logic [WIDTH-1:0]    b00, b01, b10, b11;

    logic [ARR_W-1:0]    arr_reset_d, arr_start_d;
    logic [WIDTH-1:0]    west0_d, west1_d, north0_d, north1_d;
    logic                feed_done_d;

    assign go_acc_c = go && (state_q == ST_IDLE);

    // State, skew step and drain timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic; arr_done is only honoured in DRAIN and beats the timeout
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tmo_d     = tmo_q;
        tmo_hit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
                step_d  = '0;
            end
            ST_STREAM: begin
                if (step_q == STEP_LAST) begin
                    state_d = ST_DRAIN;
                    tmo_d   = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (arr_done) begin
                    state_d = ST_FINISH;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = ST_FINISH;
                    tmo_hit_c = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Matrix register file; writes only land while the handshake shows ready
    always_ff @(posedge clk) begin
        if (rst) begin
            a00 <= '0; a01 <= '0; a10 <= '0; a11 <= '0;
            b00 <= '0; b01 <= '0; b10 <= '0; b11 <= '0;
        end else if (load_valid && load_ready) begin
            case (load_addr)
                ADDR_A00: a00 <= load_data;
                ADDR_A01: a01 <= load_data;
                ADDR_A10: a10 <= load_data;
                ADDR_A11: a11 <= load_data;
                ADDR_B00: b00 <= load_data;
                ADDR_B01: b01 <= load_data;
                ADDR_B10: b10 <= load_data;
                ADDR_B11: b11 <= load_data;
            endcase
        end
    end

    // Output decode and skew mux, driven by the current state and step
    always_comb begin
        arr_reset_d = ARR_NONE;
        arr_start_d = ARR_NONE;
        west0_d     = '0;
        west1_d     = '0;
        north0_d    = '0;
        north1_d    = '0;
        feed_done_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                arr_reset_d = ARR_RESET_ALL;
            end
            ST_STREAM: begin
                arr_start_d = ARR_START_PE;
                case (step_q)
                    2'd0: begin
                        west0_d  = a00;
                        north0_d = b00;
                    end
                    2'd1: begin
                        west0_d  = a01;
                        west1_d  = a10;
                        north0_d = b10;
                        north1_d = b01;
                    end
                    2'd2: begin
                        west1_d  = a11;
                        north1_d = b11;
                    end
                    default: begin
                    end
                endcase
            end
            ST_DRAIN: begin
                arr_start_d = ARR_START_PE;
            end
            ST_FINISH: begin
                feed_done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Output registers; handshake and busy track the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_reset   <= ARR_NONE;
            arr_start   <= ARR_NONE;
            west0       <= '0;
            west1       <= '0;
            north0      <= '0;
            north1      <= '0;
            feed_done   <= 1'b0;
            busy        <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            arr_reset   <= arr_reset_d;
            arr_start   <= arr_start_d;
            west0       <= west0_d;
            west1       <= west1_d;
            north0      <= north0_d;
            north1      <= north1_d;
            feed_done   <= feed_done_d;
            busy        <= (state_d != ST_IDLE);
            load_ready  <= (state_d == ST_IDLE);
        end
    end

    // Sticky timeout flag, cleared by an accepted go
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (go_acc_c) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit_c) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Scoreboard bench for the 2x2 systolic feeder.
module tb_systolic_feeder_2x2;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [2:0]   load_addr;
    logic [W-1:0] load_data;
    logic         go;
    logic         arr_done;
    logic [7:0]   arr_reset;
    logic [7:0]   arr_start;
    logic [W-1:0] west0, west1, north0, north1;
    logic         busy;
    logic         feed_done;
    logic         timeout_err;

    systolic_feeder_2x2 #(.WIDTH(W), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .go          (go),
        .arr_done    (arr_done),
        .arr_reset   (arr_reset),
        .arr_start   (arr_start),
        .west0       (west0),
        .west1       (west1),
        .north0      (north0),
        .north1      (north1),
        .busy        (busy),
        .feed_done   (feed_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [W-1:0] n0;
        logic [W-1:0] n1;
        logic [7:0]   rv;
        logic [7:0]   sv;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] ma[4];
    logic [W-1:0] mb[4];
    int           errors = 0;
    int           checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of one run's CLEAR + three skewed steps
    task automatic push_expect();
        sb.push_back('{w0: '0,    w1: '0,    n0: '0,    n1: '0,    rv: 8'hFF, sv: 8'h00});
        sb.push_back('{w0: ma[0], w1: '0,    n0: mb[0], n1: '0,    rv: 8'h00, sv: 8'h0F});
        sb.push_back('{w0: ma[1], w1: ma[2], n0: mb[2], n1: mb[1], rv: 8'h00, sv: 8'h0F});
        sb.push_back('{w0: '0,    w1: ma[3], n0: '0,    n1: mb[3], rv: 8'h00, sv: 8'h0F});
    endtask

    task automatic do_load(input logic [2:0] addr, input logic [W-1:0] data);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        tick();
        load_valid = 1'b0;
        if (addr < 3'd4) ma[addr[1:0]] = data;
        else             mb[addr[1:0]] = data;
    endtask

    task automatic load_abcd();
        for (int i = 0; i < 4; i++) do_load(3'(i), W'(i + 1));
        for (int i = 0; i < 4; i++) do_load(3'(i + 4), W'(i + 5));
    endtask

    task automatic start_run(input string name);
        go = 1'b1;
        push_expect();
        tick();
        go = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_go: got %b want 1", name, busy);
        end
    endtask

    task automatic check_n(input string name, input int n);
        exp_t e, got;
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard_empty: got none want entry", name);
            end else begin
                e   = sb.pop_front();
                got = '{w0: west0, w1: west1, n0: north0, n1: north1, rv: arr_reset, sv: arr_start};
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s beat%0d: got %h want %h", name, i, got, e);
                end
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (feed_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (feed_done !== 1'b1) begin
            errors++;
            $display("FAIL %s feed_done_wait: got %b want 1 within %0d cycles", name, feed_done, budget);
        end else begin
            checks++;
            if ({busy, arr_start} !== {1'b0, 8'h00}) begin
                errors++;
                $display("FAIL %s finish_outputs: got busy=%b start=%h want busy=0 start=00", name, busy, arr_start);
            end
            tick();
            checks++;
            if (feed_done !== 1'b0) begin
                errors++;
                $display("FAIL %s feed_done_pulse: got %b want 0", name, feed_done);
            end
        end
    endtask

    task automatic end_run(input string name);
        arr_done = 1'b1;
        tick();
        arr_done = 1'b0;
        wait_done(name, 8);
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({arr_reset, arr_start, west0, west1, north0, north1, busy, feed_done, timeout_err, load_ready} !== {8'h00, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s idle_outputs: got rst=%h st=%h w=%h/%h n=%h/%h busy=%b fd=%b te=%b lr=%b want all zero, load_ready=1",
                     name, arr_reset, arr_start, west0, west1, north0, north1, busy, feed_done, timeout_err, load_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0; go = 1'b0; arr_done = 1'b0;
        for (int i = 0; i < 4; i++) begin ma[i] = '0; mb[i] = '0; end
        tick(); tick();
        rst = 1'b0;
        check_idle_zero("reset");
    endtask

    task automatic test_basic();
        load_abcd();
        start_run("basic");
        check_n("basic", 4);
        arr_done = 1'b1;
        tick();
        arr_done = 1'b0;
        checks++;
        if ({arr_start, west0, west1, north0, north1} !== {8'h0F, 64'h0}) begin
            errors++;
            $display("FAIL basic drain_outputs: got st=%h w=%h/%h n=%h/%h want 0F, zeros", arr_start, west0, west1, north0, north1);
        end
        wait_done("basic", 8);
    endtask

    task automatic test_timeout();
        start_run("timeout");
        check_n("timeout", 4);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if ({timeout_err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout early: got err=%b busy=%b want err=0 busy=1", timeout_err, busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout flag: got %b want 1", timeout_err);
        end
        wait_done("timeout", 4);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout sticky: got %b want 1", timeout_err);
        end
        start_run("timeout_clear");
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout clear_on_go: got %b want 0", timeout_err);
        end
        check_n("timeout_clear", 4);
        end_run("timeout_clear");
    endtask

    task automatic test_load_with_go();
        load_valid = 1'b1; load_addr = 3'd7; load_data = W'(9);
        mb[3] = W'(9);
        start_run("load_go");
        load_valid = 1'b0;
        check_n("load_go", 1);
        load_valid = 1'b1; load_addr = 3'd0; load_data = W'(16'h0099);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_busy ready: got %b want 0", load_ready);
        end
        check_n("load_go", 3);
        load_valid = 1'b0;
        end_run("load_go");
        start_run("load_unchanged");
        check_n("load_unchanged", 4);
        end_run("load_unchanged");
    endtask

    task automatic test_reset_midrun();
        start_run("midrst");
        check_n("midrst", 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("midrst");
        sb.delete();
        for (int i = 0; i < 4; i++) begin ma[i] = '0; mb[i] = '0; end
        start_run("midrst_rerun");
        check_n("midrst_rerun", 4);
        end_run("midrst_rerun");
    endtask

    task automatic test_go_ignored();
        load_abcd();
        start_run("goign");
        check_n("goign", 4);
        go = 1'b1;
        tick();
        checks++;
        if ({busy, arr_reset} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL goign drain_go: got busy=%b rst=%h want busy=1 rst=00", busy, arr_reset);
        end
        arr_done = 1'b1;
        tick();
        arr_done = 1'b0;
        checks++;
        if ({arr_reset, arr_start} !== {8'h00, 8'h0F}) begin
            errors++;
            $display("FAIL goign drain_go2: got rst=%h st=%h want 00 0F", arr_reset, arr_start);
        end
        tick();
        go = 1'b0;
        checks++;
        if ({feed_done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL goign finish_go: got fd=%b busy=%b want fd=1 busy=0", feed_done, busy);
        end
        start_run("goign_next");
        check_n("goign_next", 4);
        end_run("goign_next");
    endtask

    task automatic test_done_in_stream();
        arr_done = 1'b1;
        start_run("done_stream");
        check_n("done_stream", 4);
        arr_done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({busy, feed_done, arr_start} !== {1'b1, 1'b0, 8'h0F}) begin
            errors++;
            $display("FAIL done_stream still_drain: got busy=%b fd=%b st=%h want 1 0 0F", busy, feed_done, arr_start);
        end
        end_run("done_stream");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_load_with_go();
        test_reset_midrun();
        test_go_ignored();
        test_done_in_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_feeder_2x2.md
Name: systolic_feeder_2x2

Overview:
Sequencer and skew generator that drives the operand side of the 2x2 systolic array. It holds one 2x2 A matrix and one 2x2 B matrix, loaded through a simple write port. On a go pulse it clears the array, streams A rows west and B columns north in diagonal (skewed) order, and holds start until the array reports done. It sits between the coprocessor register interface and the array's west/north operand, start and reset inputs.

Parameters:
WIDTH, 16, operand width; must match the array's WIDTH.
TIMEOUT, 15, maximum DRAIN cycles to wait for arr_done before flagging an error (4-bit counter, 1..15).

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous active-high reset.
load_valid  input  1  matrix element write request.
load_ready  output  1  high only in IDLE; a write occurs when load_valid && load_ready.
load_addr  input  3  0..3 = A00,A01,A10,A11; 4..7 = B00,B01,B10,B11.
load_data  input  WIDTH  element value.
go  input  1  single-cycle request to run one multiply.
arr_done  input  1  done from the array.
arr_reset  output  8  to the array reset vector.
arr_start  output  8  to the array start vector.
west0, west1  output  WIDTH  to the array inp_west0_buf and inp_west1_buf.
north0, north1  output  WIDTH  to the array inp_north0_buf and inp_north1_buf.
busy  output  1  high in every state except IDLE.
feed_done  output  1  one-cycle pulse when the run completes.
timeout_err  output  1  sticky error flag; cleared by the next accepted go or by rst.

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; all matrix registers = 0; west/north = 0; arr_reset = 0; arr_start = 0; busy = 0; feed_done = 0; timeout_err = 0; load_ready = 1 on the first cycle after reset.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, FINISH.
- IDLE:
  - load_ready = 1; writes update the addressed register.
  - go moves to CLEAR and clears timeout_err.
  - A load and go in the same cycle: the write commits and is used by this run.
- CLEAR (1 cycle):
  - arr_reset = 8'hFF, arr_start = 0, operands = 0.
  - Next state is STREAM.
- STREAM (3 cycles, step s = 0, 1, 2; arr_reset = 0; arr_start = 8'h0F):
  - s0: west0 = A00, north0 = B00, west1 = 0, north1 = 0.
  - s1: west0 = A01, west1 = A10, north0 = B10, north1 = B01.
  - s2: west0 = 0, west1 = A11, north0 = 0, north1 = B11.
  - After s2, next state is DRAIN.
- DRAIN:
  - Operands = 0; arr_start stays 8'h0F; the timeout counter increments each cycle.
  - arr_done = 1 moves to FINISH.
  - If the counter reaches TIMEOUT without arr_done: set timeout_err and move to FINISH.
  - If arr_done and the timeout occur in the same cycle, done wins and timeout_err is not set.
- FINISH (1 cycle):
  - feed_done = 1, arr_start = 0.
  - Next state is IDLE.
- arr_done seen in any state other than DRAIN is ignored.
- go outside IDLE is ignored; requests are not queued.
- load_valid while load_ready = 0 is dropped; matrix registers do not change while busy.
- Latency: go sampled at edge N gives arr_reset high during cycle N+1 and s0 operands during cycle N+2.
- Registered outputs change one cycle after the state transition that causes them.
- rst asserted mid-run: next cycle returns to IDLE with every output at its reset value and matrices zeroed. arr_reset is not pulsed by rst; the array has its own reset.
- Widths: operands pass through unmodified; no arithmetic on data.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams).
  - Load address constants A00..B11.
  - Array control vector constants ARR_RESET_ALL = 8'hFF and ARR_START_PE = 8'h0F.
- No sub-module is needed. A matrix register file plus a skew mux in the same module is natural; the skew mux is pure combinational, indexed by the STREAM step, into the output registers.

Test Plan:
- Load A = {1,2,3,4}, B = {5,6,7,8}, then go:
  - arr_reset = FF for one cycle.
  - Operands (west0, west1, north0, north1) over s0, s1, s2 = (1,0,5,0), (2,3,7,6), (0,4,0,8).
  - With the real array attached, results = 19, 22, 43, 50 and feed_done pulses once.
- go with arr_done tied 0: DRAIN lasts 15 cycles, then timeout_err = 1, feed_done pulses, busy drops. The next go clears timeout_err.
- Write addr 7 = 9 in the same cycle as go: s2 north1 = 9. A load attempted during STREAM shows load_ready = 0 and the register is unchanged.
- Assert rst during STREAM s1: next cycle all outputs = 0, busy = 0, and reading back via a fresh run shows all operands = 0.
- go pulsed during DRAIN and again in FINISH: neither starts a run. A go the cycle after FINISH (IDLE) is accepted normally.
- arr_done pulsed during STREAM: ignored; the FSM completes all 3 steps and still waits in DRAIN.
